// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//   Multiplies finish in two cycles; divides/remainders use a radix-2
//   restoring loop (one quotient bit per cycle) followed by a sign-fix
//   cycle. Divide-by-zero and signed overflow finish after one cycle.
//   The pipeline is held via stall while an operation is in flight.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : EX holds an M-ext instruction (level, held while stalled)
//   flush  : EX instruction squashed; abandon any operation
//   op     : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   src0   : rs1 after forwarding (multiplicand / dividend)
//   src1   : rs2 after forwarding (multiplier / divisor)
//   stall  : freeze IF/ID/EX (combinational)
//   done   : one-cycle pulse, result valid
//   result : registered result, held until the next completion
module ex_muldiv #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(DIV_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [CW-1:0]   r_cnt;
  logic            r_neg0;
  logic            r_neg1;
  logic [XLEN-1:0] r_result;

  logic            w_signed;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_mag0;
  logic [XLEN-1:0] w_mag1;

  logic [XLEN:0]     w_a_ext;
  logic [XLEN:0]     w_b_ext;
  logic [2*XLEN-1:0] w_a_wide;
  logic [2*XLEN-1:0] w_b_wide;
  logic [2*XLEN-1:0] w_prod;

  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  assign result = r_result;

  // Signed divide/remainder are the even funct3 codes with op[2] set.
  assign w_signed   = ~op[0];
  assign w_div_zero = (src1 == '0);
  assign w_div_ovf  = w_signed && (src0 == {1'b1, {(XLEN-1){1'b0}}}) && (src1 == '1);
  assign w_mag0     = (w_signed && src0[XLEN-1]) ? -src0 : src0;
  assign w_mag1     = (w_signed && src1[XLEN-1]) ? -src1 : src1;

  // MULH: both signed; MULHSU: src0 only; MULHU: neither. The 33-bit
  // operands are widened to 2*XLEN so a plain unsigned multiply yields
  // the correct low 64 bits of the signed product.
  assign w_a_ext  = {((r_op == 2'b01) || (r_op == 2'b10)) & r_a[XLEN-1], r_a};
  assign w_b_ext  = {(r_op == 2'b01) & r_b[XLEN-1], r_b};
  assign w_a_wide = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
  assign w_b_wide = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
  assign w_prod   = w_a_wide * w_b_wide;

  // Restoring step. The running remainder is always below the divisor,
  // so whenever the trial succeeds the difference fits in XLEN bits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[XLEN-1:0] - r_b;

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          stall = 1'b1;
          if (!op[2])                      w_next = S_MUL;
          else if (w_div_zero || w_div_ovf) w_next = S_DONE;
          else                             w_next = S_DIV;
        end
      end
      S_MUL: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (r_cnt == CW'(DIV_ITER - 1)) w_next = S_FIX;
      end
      S_FIX: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
      stall  = 1'b0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_neg0   <= 1'b0;
      r_neg1   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (!flush) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_op <= op[1:0];
              if (!op[2]) begin
                r_a <= src0;
                r_b <= src1;
              end else if (w_div_zero) begin
                r_result <= op[1] ? src0 : '1;
              end else if (w_div_ovf) begin
                r_result <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              end else begin
                r_rem  <= '0;
                r_quo  <= w_mag0;
                r_b    <= w_mag1;
                r_cnt  <= '0;
                r_neg0 <= w_signed & src0[XLEN-1];
                r_neg1 <= w_signed & src1[XLEN-1];
              end
            end
          end
          S_MUL: begin
            r_result <= (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
          end
          S_DIV: begin
            r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
          S_FIX: begin
            if (r_op[1]) r_result <= r_neg0 ? -r_rem : r_rem;
            else         r_result <= (r_neg0 ^ r_neg1) ? -r_quo : r_quo;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
